// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle between the 5-stage pipeline datapath and its hazard/stall
//   controller.
//   master : pipeline side. Drives the hazard inputs and receives the strobes.
//   slave  : controller side. Receives the hazard inputs and drives the strobes.
//   Hazard inputs : dec_rs1/2, dec_uses_rs1/2, ex_rd, ex_reg_write,
//                   ex_is_load, branch_taken, mem_busy, ex_mc_start,
//                   ex_mc_done
//   Strobes/debug : pc_en, fetch_en, fetch_flush, decode_en, decode_flush,
//                   ex_en, stall_count, timeout_err, state_dbg
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int RWIDTH = 5,
  parameter int DWIDTH = 32
);
  logic [RWIDTH-1:0] dec_rs1;
  logic [RWIDTH-1:0] dec_rs2;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  logic [RWIDTH-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_is_load;
  logic              branch_taken;
  logic              mem_busy;
  logic              ex_mc_start;
  logic              ex_mc_done;

  logic              pc_en;
  logic              fetch_en;
  logic              fetch_flush;
  logic              decode_en;
  logic              decode_flush;
  logic              ex_en;
  logic [DWIDTH-1:0] stall_count;
  logic              timeout_err;
  logic [1:0]        state_dbg;

  modport master (
    output dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2, ex_rd, ex_reg_write,
           ex_is_load, branch_taken, mem_busy, ex_mc_start, ex_mc_done,
    input  pc_en, fetch_en, fetch_flush, decode_en, decode_flush, ex_en,
           stall_count, timeout_err, state_dbg
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2, ex_rd, ex_reg_write,
           ex_is_load, branch_taken, mem_busy, ex_mc_start, ex_mc_done,
    output pc_en, fetch_en, fetch_flush, decode_en, decode_flush, ex_en,
           stall_count, timeout_err, state_dbg
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard and stall controller for a 5-stage pipeline. Produces the PC,
//   fetch, decode and execute/memory register enables and flushes for
//   load-use hazards, taken branches, data-memory wait states and multicycle
//   execute operations. Strobes are Mealy outputs of the registered state.
//   Also keeps a saturating stall counter and a sticky wait-timeout flag.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-high reset
//     bus  : pipeline_ctrl_if.slave (hazard inputs in, strobes/debug out)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int RWIDTH  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_MEM = 2'd1,
    S_EXB = 2'd2
  } state_t;

  // wait counter only needs to reach TIMEOUT; saturation keeps it there
  localparam int              WCW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0]  TO_VAL = WCW'(TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_stall_cnt;
  logic [WCW-1:0]    r_wait_cnt;
  logic              r_timeout;

  logic              w_lu;
  logic              w_pc_en;
  logic              w_fetch_en;
  logic              w_fetch_flush;
  logic              w_decode_en;
  logic              w_decode_flush;
  logic              w_ex_en;
  logic [WCW-1:0]    w_wait_inc;

  function automatic logic [DWIDTH-1:0] sat_inc_stall(input logic [DWIDTH-1:0] v);
    return (&v) ? v : v + {{(DWIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WCW-1:0] sat_inc_wait(input logic [WCW-1:0] v);
    return (&v) ? v : v + {{(WCW-1){1'b0}}, 1'b1};
  endfunction

  // load in execute whose destination is read by the decode instruction;
  // x0 never carries a dependency
  assign w_lu = bus.ex_is_load && bus.ex_reg_write && (bus.ex_rd != '0) &&
                ((bus.dec_uses_rs1 && (bus.dec_rs1 == bus.ex_rd)) ||
                 (bus.dec_uses_rs2 && (bus.dec_rs2 == bus.ex_rd)));

  assign w_wait_inc = sat_inc_wait(r_wait_cnt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN, S_MEM: begin
        // leaving MEM_WAIT applies the RUN rules in the same cycle
        if (bus.mem_busy)                               w_state_nxt = S_MEM;
        else if (bus.branch_taken)                      w_state_nxt = S_RUN;
        else if (bus.ex_mc_start && !bus.ex_mc_done)    w_state_nxt = S_EXB;
        else                                            w_state_nxt = S_RUN;
      end
      S_EXB: begin
        if (!bus.mem_busy && bus.ex_mc_done)            w_state_nxt = S_RUN;
      end
      default:                                          w_state_nxt = S_RUN;
    endcase
  end

  // Output logic (Mealy strobes)
  always_comb begin
    w_pc_en        = 1'b0;
    w_fetch_en     = 1'b0;
    w_fetch_flush  = 1'b0;
    w_decode_en    = 1'b0;
    w_decode_flush = 1'b0;
    w_ex_en        = 1'b0;
    if (!rst && !bus.mem_busy) begin
      if (r_state == S_EXB) begin
        // branch_taken is deliberately not looked at while waiting on a
        // multicycle result
        if (bus.ex_mc_done) begin
          w_pc_en     = 1'b1;
          w_fetch_en  = 1'b1;
          w_decode_en = 1'b1;
          w_ex_en     = 1'b1;
        end
      end else if (bus.branch_taken) begin
        w_pc_en        = 1'b1;
        w_fetch_en     = 1'b1;
        w_fetch_flush  = 1'b1;
        w_decode_en    = 1'b1;
        w_decode_flush = 1'b1;
        w_ex_en        = 1'b1;
      end else if (bus.ex_mc_start) begin
        // a result already valid in its first cycle needs no wait
        if (bus.ex_mc_done) begin
          w_pc_en     = 1'b1;
          w_fetch_en  = 1'b1;
          w_decode_en = 1'b1;
          w_ex_en     = 1'b1;
        end
      end else if (w_lu) begin
        // hold PC/fetch, push one bubble into execute
        w_decode_en    = 1'b1;
        w_decode_flush = 1'b1;
        w_ex_en        = 1'b1;
      end else begin
        w_pc_en     = 1'b1;
        w_fetch_en  = 1'b1;
        w_decode_en = 1'b1;
        w_ex_en     = 1'b1;
      end
    end
  end

  // Debug counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (!w_pc_en) begin
        r_stall_cnt <= sat_inc_stall(r_stall_cnt);
      end
      if (r_state != S_RUN) begin
        r_wait_cnt <= w_wait_inc;
        if ((TIMEOUT != 0) && (w_wait_inc == TO_VAL)) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.fetch_en     = w_fetch_en;
  assign bus.fetch_flush  = w_fetch_flush;
  assign bus.decode_en    = w_decode_en;
  assign bus.decode_flush = w_decode_flush;
  assign bus.ex_en        = w_ex_en;
  assign bus.stall_count  = r_stall_cnt;
  assign bus.timeout_err  = r_timeout;
  assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int DW = 5;   // small counter so saturation is reachable
  localparam int RW = 5;

  // strobe encoding {pc_en, fetch_en, fetch_flush, decode_en, decode_flush, ex_en}
  localparam logic [5:0] ZERO = 6'b000000;
  localparam logic [5:0] NORM = 6'b110101;
  localparam logic [5:0] BR   = 6'b111111;
  localparam logic [5:0] LU   = 6'b000111;

  typedef struct packed {
    logic [RW-1:0] rs1, rs2, rd;
    logic u1, u2, rw, ld, br, mb, mcs, mcd, rst;
  } stim_t;

  typedef struct {
    string      name;
    logic [5:0] strb;
    logic [1:0] st;
    int         sc;
    logic       to;
  } exp_t;

  logic clk;
  logic rst;
  stim_t nx;
  exp_t q[$];
  int checks;
  int passed;

  pipeline_ctrl_if #(.RWIDTH(RW), .DWIDTH(DW)) bus ();

  pipeline_ctrl #(.DWIDTH(DW), .RWIDTH(RW), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // apply staged inputs shortly after the edge and record the expected response
  task automatic step(input string name, input logic [5:0] strb, input logic [1:0] st,
                      input int sc, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = nx.rst;
    bus.dec_rs1      = nx.rs1;
    bus.dec_rs2      = nx.rs2;
    bus.ex_rd        = nx.rd;
    bus.dec_uses_rs1 = nx.u1;
    bus.dec_uses_rs2 = nx.u2;
    bus.ex_reg_write = nx.rw;
    bus.ex_is_load   = nx.ld;
    bus.branch_taken = nx.br;
    bus.mem_busy     = nx.mb;
    bus.ex_mc_start  = nx.mcs;
    bus.ex_mc_done   = nx.mcd;
    e.name = name; e.strb = strb; e.st = st; e.sc = sc; e.to = to;
    q.push_back(e);
  endtask

  // monitor: the strobes are valid every cycle, compare mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] a;
      e = q.pop_front();
      a = {bus.pc_en, bus.fetch_en, bus.fetch_flush, bus.decode_en, bus.decode_flush, bus.ex_en};
      checks++;
      if (a === e.strb && bus.state_dbg === e.st && int'(bus.stall_count) == e.sc &&
          bus.timeout_err === e.to) begin
        passed++;
      end else begin
        $display("FAIL %s: got strb=%b st=%0d sc=%0d to=%b, want strb=%b st=%0d sc=%0d to=%b",
                 e.name, a, bus.state_dbg, bus.stall_count, bus.timeout_err,
                 e.strb, e.st, e.sc, e.to);
      end
    end
  end

  function automatic int sat(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.ex_rd = '0;
    bus.dec_uses_rs1 = 1'b0; bus.dec_uses_rs2 = 1'b0;
    bus.ex_reg_write = 1'b0; bus.ex_is_load = 1'b0; bus.branch_taken = 1'b0;
    bus.mem_busy = 1'b0; bus.ex_mc_start = 1'b0; bus.ex_mc_done = 1'b0;

    nx = '0; nx.rst = 1'b1;
    step("reset", ZERO, 2'd0, 0, 1'b0);
    nx = '0;
    step("idle", NORM, 2'd0, 0, 1'b0);

    // load-use on rs2
    nx = '0; nx.ld = 1; nx.rw = 1; nx.rd = 5; nx.rs2 = 5; nx.u2 = 1;
    step("lu_rs2", LU, 2'd0, 0, 1'b0);
    nx = '0;
    step("lu_clear", NORM, 2'd0, 1, 1'b0);
    // x0 destination carries no hazard
    nx = '0; nx.ld = 1; nx.rw = 1; nx.rd = 0; nx.rs2 = 0; nx.u2 = 1;
    step("lu_x0", NORM, 2'd0, 1, 1'b0);
    // load-use on rs1
    nx = '0; nx.ld = 1; nx.rw = 1; nx.rd = 7; nx.rs1 = 7; nx.u1 = 1;
    step("lu_rs1", LU, 2'd0, 1, 1'b0);
    // matching index but operand not read
    nx = '0; nx.ld = 1; nx.rw = 1; nx.rd = 7; nx.rs1 = 7; nx.u1 = 0;
    step("lu_unused", NORM, 2'd0, 2, 1'b0);

    // branch wins over load-use
    nx = '0; nx.br = 1; nx.ld = 1; nx.rw = 1; nx.rd = 5; nx.rs2 = 5; nx.u2 = 1;
    step("br_lu", BR, 2'd0, 2, 1'b0);
    nx = '0;
    step("br_after", NORM, 2'd0, 2, 1'b0);

    // memory wait for 4 cycles
    nx = '0; nx.mb = 1;
    step("mem0", ZERO, 2'd0, 2, 1'b0);
    step("mem1", ZERO, 2'd1, 3, 1'b0);
    step("mem2", ZERO, 2'd1, 4, 1'b0);
    step("mem3", ZERO, 2'd1, 5, 1'b0);
    nx = '0;
    step("mem_drop", NORM, 2'd1, 6, 1'b0);
    step("mem_run", NORM, 2'd0, 6, 1'b0);

    // multicycle, done 6 cycles after start, branch ignored while busy
    nx = '0; nx.mcs = 1;
    step("mc_start", ZERO, 2'd0, 6, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      nx = '0; nx.br = (k == 3);
      step($sformatf("mc_busy%0d", k), ZERO, 2'd2, 6 + k, 1'b0);
    end
    nx = '0; nx.mcd = 1;
    step("mc_done", NORM, 2'd2, 12, 1'b0);
    nx = '0;
    step("mc_run", NORM, 2'd0, 12, 1'b0);

    // multicycle with memory busy on the done cycle
    nx = '0; nx.mcs = 1;
    step("mcm_start", ZERO, 2'd0, 12, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      nx = '0;
      step($sformatf("mcm_busy%0d", k), ZERO, 2'd2, 12 + k, 1'b0);
    end
    nx = '0; nx.mcd = 1; nx.mb = 1;
    step("mcm_frz", ZERO, 2'd2, 18, 1'b0);
    nx = '0; nx.mcd = 1;
    step("mcm_done", NORM, 2'd2, 19, 1'b0);
    nx = '0;
    step("mcm_run", NORM, 2'd0, 19, 1'b0);

    // multicycle done in its start cycle
    nx = '0; nx.mcs = 1; nx.mcd = 1;
    step("mc_fast", NORM, 2'd0, 19, 1'b0);
    nx = '0;
    step("mc_fast_run", NORM, 2'd0, 19, 1'b0);

    // timeout after 8 wait cycles; stall counter saturates at 31
    nx = '0; nx.mb = 1;
    step("to0", ZERO, 2'd0, 19, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      step($sformatf("to%0d", k), ZERO, 2'd1, sat(19 + k), logic'(k >= 9));
    end
    nx = '0;
    step("to_drop", NORM, 2'd1, 31, 1'b1);
    step("to_sticky", NORM, 2'd0, 31, 1'b1);

    // reset mid-multicycle at wait_cnt=3
    nx = '0; nx.mcs = 1;
    step("rm_start", ZERO, 2'd0, 31, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      nx = '0;
      step($sformatf("rm_busy%0d", k), ZERO, 2'd2, 31, 1'b1);
    end
    nx = '0; nx.rst = 1; nx.mcd = 1; nx.br = 1;
    step("rm_rst", ZERO, 2'd0, 0, 1'b0);
    nx = '0;
    step("rm_release", NORM, 2'd0, 0, 1'b0);
    step("rm_run", NORM, 2'd0, 0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
